// File: rtl/pc_fetch_sequencer_pkg.sv
// Shared types and constants for the PC fetch sequencer and its opcode classifier.
package pc_fetch_sequencer_pkg;

  typedef enum logic [2:0] {
    RESET_S = 3'd0,
    FETCH   = 3'd1,
    DECODE  = 3'd2,
    EXEC    = 3'd3,
    UPDATE  = 3'd4
  } state_t;

  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 26;
  localparam int OPC_W   = OPC_MSB - OPC_LSB + 1;

  localparam logic [OPC_W-1:0] OPC_J   = 6'b000010;
  localparam logic [OPC_W-1:0] OPC_JAL = 6'b000011;
  localparam logic [OPC_W-1:0] OPC_BEQ = 6'b000100;
  localparam logic [OPC_W-1:0] OPC_BNE = 6'b000101;

  localparam int TIMEOUT_CYCLES = 16;

  function automatic logic [OPC_W-1:0] opcode_of(input logic [31:0] word);
    return word[OPC_MSB:OPC_LSB];
  endfunction

endpackage

// File: rtl/pc_fetch_sequencer_opcode_classifier.sv
// Combinational opcode classifier: flags jump and conditional-branch opcodes.
// Shared with the hazard unit, so it must stay purely combinational.
module pc_fetch_sequencer_opcode_classifier
  import pc_fetch_sequencer_pkg::*;
(
  input  logic [OPC_W-1:0] opcode,
  output logic             is_jump,
  output logic             is_beq,
  output logic             is_bne
);

  assign is_jump = (opcode == OPC_J) || (opcode == OPC_JAL);
  assign is_beq  = (opcode == OPC_BEQ);
  assign is_bne  = (opcode == OPC_BNE);

endmodule

// File: rtl/pc_fetch_sequencer.sv
// Multi-cycle fetch/decode/execute/update sequencer; sole source of PC write enables.
// Optional fetch watchdog enabled by defining FETCH_TIMEOUT_EN.
module pc_fetch_sequencer
  import pc_fetch_sequencer_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        exec_start,
  input  logic        exec_done,
  input  logic        alu_zero,
  input  logic        stall,
  output logic        pc_step,
  output logic        jump,
  output logic        branch,
  output logic        fetch_err
);

  state_t      state_r, state_s;
  logic        imem_req_r, req_s;
  logic        exec_start_r, start_s;
  logic [31:0] instr_r;
  logic        is_jump_r, is_beq_r, is_bne_r, taken_r;
  logic        fetch_ok_s, step_s;
  logic        dec_jump_s, dec_beq_s, dec_bne_s;

  pc_fetch_sequencer_opcode_classifier u_classifier (
    .opcode  (opcode_of(instr_r)),
    .is_jump (dec_jump_s),
    .is_beq  (dec_beq_s),
    .is_bne  (dec_bne_s)
  );

`ifdef FETCH_TIMEOUT_EN
  localparam logic [4:0] TMO_LAST = 5'(TIMEOUT_CYCLES - 1);
  logic [4:0] tmo_cnt_r;
  logic       fetch_err_r;

  // Watchdog: count unacknowledged request cycles, flag a sticky error on expiry
  always_ff @(posedge clk) begin
    if (!reset) begin
      tmo_cnt_r   <= 5'd0;
      fetch_err_r <= 1'b0;
    end else if (state_r == FETCH && imem_req_r && !imem_ack) begin
      if (tmo_cnt_r == TMO_LAST) begin
        tmo_cnt_r   <= 5'd0;
        fetch_err_r <= 1'b1;
      end else begin
        tmo_cnt_r   <= tmo_cnt_r + 5'd1;
      end
    end else begin
      tmo_cnt_r <= 5'd0;
    end
  end

  assign fetch_err = fetch_err_r;
`else
  assign fetch_err = 1'b0;
`endif

  // Next-state and strobe decode
  always_comb begin
    state_s    = state_r;
    req_s      = imem_req_r;
    start_s    = 1'b0;
    fetch_ok_s = 1'b0;
    step_s     = 1'b0;
    case (state_r)
      RESET_S: begin
        state_s = FETCH;
        req_s   = 1'b1;
      end
      FETCH: begin
        // an ack only counts while the request is actually up
        if (imem_req_r && imem_ack) begin
          fetch_ok_s = 1'b1;
          start_s    = 1'b1;
          req_s      = 1'b0;
          state_s    = DECODE;
        end else begin
`ifdef FETCH_TIMEOUT_EN
          if (!imem_req_r) begin
            req_s = 1'b1;
          end else if (tmo_cnt_r == TMO_LAST) begin
            req_s = 1'b0;
          end else begin
            req_s = 1'b1;
          end
`else
          req_s = 1'b1;
`endif
        end
      end
      DECODE: begin
        state_s = EXEC;
      end
      EXEC: begin
        if (exec_done) begin
          state_s = UPDATE;
        end else begin
          state_s = EXEC;
        end
      end
      UPDATE: begin
        if (!stall) begin
          step_s  = 1'b1;
          req_s   = 1'b1;
          state_s = FETCH;
        end else begin
          state_s = UPDATE;
        end
      end
      default: begin
        state_s = RESET_S;
        req_s   = 1'b0;
      end
    endcase
  end

  // State, instruction register and per-instruction flags
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r      <= RESET_S;
      imem_req_r   <= 1'b0;
      exec_start_r <= 1'b0;
      instr_r      <= 32'd0;
      is_jump_r    <= 1'b0;
      is_beq_r     <= 1'b0;
      is_bne_r     <= 1'b0;
      taken_r      <= 1'b0;
    end else begin
      state_r      <= state_s;
      imem_req_r   <= req_s;
      exec_start_r <= start_s;
      if (fetch_ok_s) begin
        instr_r <= imem_rdata;
      end
      if (state_r == DECODE) begin
        is_jump_r <= dec_jump_s;
        is_beq_r  <= dec_beq_s;
        is_bne_r  <= dec_bne_s;
      end
      if (state_r == EXEC && exec_done) begin
        taken_r <= (is_beq_r & alu_zero) | (is_bne_r & ~alu_zero);
      end
    end
  end

  // PC strobes fire in the UPDATE cycle itself so the PC is new when FETCH starts
  assign imem_req   = imem_req_r;
  assign exec_start = exec_start_r;
  assign instr      = instr_r;
  assign pc_step    = step_s;
  assign jump       = step_s & is_jump_r;
  assign branch     = step_s & taken_r & ~is_jump_r;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Self-checking bench for pc_fetch_sequencer: directed instruction scenarios plus
// randomized traffic, all compared every cycle against a cycle-level behavioural model.
module tb_pc_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset, imem_ack, exec_done, alu_zero, stall;
  logic [31:0] imem_rdata;
  logic        imem_req, exec_start, pc_step, jump, branch, fetch_err;
  logic [31:0] instr;

  always #5 clk = ~clk;

  pc_fetch_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .imem_req   (imem_req),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .instr      (instr),
    .exec_start (exec_start),
    .exec_done  (exec_done),
    .alu_zero   (alu_zero),
    .stall      (stall),
    .pc_step    (pc_step),
    .jump       (jump),
    .branch     (branch),
    .fetch_err  (fetch_err)
  );

  localparam int P_RST = 0, P_FET = 1, P_DEC = 2, P_EXE = 3, P_UPD = 4;

  int n_cmp = 0, n_bad = 0, cyc = 0;
  int last_step = -100, prev_step = -100, n_steps = 0;

  // Behavioural model: which phase the instruction is in, plus what the outputs must hold
  int          m_ph = P_RST, m_wait = 0;
  logic [31:0] m_instr = 32'd0;
  logic        m_req = 1'b0, m_es = 1'b0, m_taken = 1'b0, m_err = 1'b0;

  function automatic logic [5:0] opf(input logic [31:0] w);
    return w[31:26];
  endfunction

  task automatic cmp1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic cmp32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_all();
    logic is_j, e_step;
    is_j   = (opf(m_instr) == 6'b000010) || (opf(m_instr) == 6'b000011);
    e_step = (m_ph == P_UPD) && !stall;
    cmp1("imem_req", imem_req, m_req);
    cmp1("exec_start", exec_start, m_es);
    cmp32("instr", instr, m_instr);
    cmp1("pc_step", pc_step, e_step);
    cmp1("jump", jump, e_step && is_j);
    cmp1("branch", branch, e_step && m_taken && !is_j);
    cmp1("fetch_err", fetch_err, m_err);
    if (pc_step === 1'b1) begin
      prev_step = last_step;
      last_step = cyc;
      n_steps++;
    end
  endtask

  task automatic model_step();
    if (!reset) begin
      m_ph = P_RST; m_instr = 32'd0; m_req = 1'b0; m_es = 1'b0;
      m_taken = 1'b0; m_err = 1'b0; m_wait = 0;
    end else begin
      m_es = 1'b0;
      case (m_ph)
        P_RST: begin m_ph = P_FET; m_req = 1'b1; m_wait = 0; end
        P_FET: begin
          if (m_req && imem_ack) begin
            m_instr = imem_rdata; m_req = 1'b0; m_es = 1'b1; m_ph = P_DEC;
          end else begin
`ifdef FETCH_TIMEOUT_EN
            if (!m_req) m_req = 1'b1;
            else begin
              m_wait++;
              if (m_wait == 16) begin m_err = 1'b1; m_req = 1'b0; m_wait = 0; end
            end
`endif
          end
        end
        P_DEC: m_ph = P_EXE;
        P_EXE: if (exec_done) begin
          m_taken = ((opf(m_instr) == 6'b000100) && alu_zero) ||
                    ((opf(m_instr) == 6'b000101) && !alu_zero);
          m_ph = P_UPD;
        end
        P_UPD: if (!stall) begin m_ph = P_FET; m_req = 1'b1; m_wait = 0; end
        default: m_ph = P_RST;
      endcase
    end
  endtask

  task automatic drive(input logic r, input logic a, input logic [31:0] d,
                       input logic dn, input logic z, input logic s);
    @(negedge clk);
    reset = r; imem_ack = a; imem_rdata = d; exec_done = dn; alu_zero = z; stall = s;
    #1;
    check_all();
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    cyc++;
  endtask

  // Starts in the first FETCH cycle, acks immediately, exec_done right after exec_start
  task automatic run_instr(input logic [31:0] w, input logic z, input int stalls,
                           input logic ej, input logic eb);
    drive(1'b1, 1'b1, w, 1'b0, 1'b0, 1'b0);
    cmp1("req_first_fetch", imem_req, 1'b1);
    tick();
    drive(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    cmp1("exec_start_decode", exec_start, 1'b1);
    cmp32("instr_captured", instr, w);
    tick();
    drive(1'b1, 1'b0, 32'd0, 1'b1, z, 1'b0);
    cmp1("no_step_exec", pc_step, 1'b0);
    tick();
    for (int i = 0; i < stalls; i++) begin
      drive(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
      cmp1("no_step_stall", pc_step, 1'b0);
      tick();
    end
    drive(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    cmp1("step_pulse", pc_step, 1'b1);
    cmp1("step_jump", jump, ej);
    cmp1("step_branch", branch, eb);
    tick();
  endtask

  initial begin
    logic [31:0] w;
    logic [5:0]  op;
    reset = 1'b0; imem_ack = 1'b0; imem_rdata = 32'd0;
    exec_done = 1'b0; alu_zero = 1'b0; stall = 1'b0;
    tick();

    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b0);
      cmp1("rst_req", imem_req, 1'b0);
      cmp1("rst_step", pc_step, 1'b0);
      cmp32("rst_instr", instr, 32'd0);
      tick();
    end
    drive(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    cmp1("reset_s_req", imem_req, 1'b0);
    tick();

    run_instr(32'h2008_0005, 1'b0, 0, 1'b0, 1'b0);
    run_instr(32'h2008_0005, 1'b0, 0, 1'b0, 1'b0);
    cmp32("period", 32'(last_step - prev_step), 32'd4);
    run_instr(32'h0800_0010, 1'b1, 0, 1'b1, 1'b0);
    run_instr(32'h0C00_0010, 1'b0, 0, 1'b1, 1'b0);
    run_instr(32'h1109_FFFE, 1'b1, 0, 1'b0, 1'b1);
    run_instr(32'h1109_FFFE, 1'b0, 0, 1'b0, 1'b0);
    run_instr(32'h1509_FFFE, 1'b0, 0, 1'b0, 1'b1);
    run_instr(32'h1509_FFFE, 1'b1, 0, 1'b0, 1'b0);
    run_instr(32'h2008_0005, 1'b0, 3, 1'b0, 1'b0);

    // reset during EXEC aborts without a PC step
    drive(1'b1, 1'b1, 32'h1109_FFFE, 1'b0, 1'b0, 1'b0); tick();
    drive(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0); tick();
    drive(1'b0, 1'b1, 32'd0, 1'b1, 1'b1, 1'b0);
    cmp1("abort_no_step", pc_step, 1'b0);
    tick();
    drive(1'b1, 1'b0, 32'd0, 1'b1, 1'b1, 1'b0);
    cmp1("abort_step", pc_step, 1'b0);
    cmp1("abort_req", imem_req, 1'b0);
    cmp32("abort_instr", instr, 32'd0);
    tick();

`ifdef FETCH_TIMEOUT_EN
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
      cmp1("tmo_err_low", fetch_err, 1'b0);
      cmp1("tmo_req_high", imem_req, 1'b1);
      tick();
    end
    drive(1'b1, 1'b1, 32'h2008_0005, 1'b0, 1'b0, 1'b0);
    cmp1("tmo_err_set", fetch_err, 1'b1);
    cmp1("tmo_req_drop", imem_req, 1'b0);
    tick();
    run_instr(32'h2008_0005, 1'b0, 0, 1'b0, 1'b0);
    cmp1("tmo_err_sticky", fetch_err, 1'b1);
`else
    drive(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    cmp1("fetch_wait_req", imem_req, 1'b1);
    tick();
    run_instr(32'h2008_0005, 1'b0, 0, 1'b0, 1'b0);
    cmp1("no_err_default", fetch_err, 1'b0);
`endif

    for (int i = 0; i < 4000; i++) begin
      case ($urandom_range(0, 4))
        0:       op = 6'b000010;
        1:       op = 6'b000011;
        2:       op = 6'b000100;
        3:       op = 6'b000101;
        default: op = 6'($urandom);
      endcase
      w = {op, 26'($urandom)};
      drive($urandom_range(0, 249) != 0, $urandom_range(0, 2) == 0, w,
            $urandom_range(0, 2) == 0, 1'($urandom), $urandom_range(0, 2) == 0);
      tick();
    end
    if (n_steps < 50) begin
      n_bad++;
      $display("FAIL step_activity: got %0d pc_step pulses expected at least 50", n_steps);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
